// File: rtl/mio_arbiter_if.sv
// Shared data-memory port bundle: two requester channels plus the single memory-side channel.
// The arbiter takes the slave view; requesters and memory model take the master view.
interface mio_arbiter_if;
    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic [2:0]  ctrl0;
    logic        ack0;
    logic        err0;
    logic [31:0] rdata0;

    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic [2:0]  ctrl1;
    logic        ack1;
    logic        err1;
    logic [31:0] rdata1;

    logic        mem_req;
    logic        mem_w;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  dm_ctrl;
    logic        mem_owner;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0, ctrl0,
        input  req1, we1, addr1, wdata1, ctrl1,
        input  mem_ready, mem_rdata,
        output ack0, err0, rdata0, ack1, err1, rdata1,
        output mem_req, mem_w, mem_addr, mem_wdata, dm_ctrl, mem_owner
    );

    modport master (
        output req0, we0, addr0, wdata0, ctrl0,
        output req1, we1, addr1, wdata1, ctrl1,
        output mem_ready, mem_rdata,
        input  ack0, err0, rdata0, ack1, err1, rdata1,
        input  mem_req, mem_w, mem_addr, mem_wdata, dm_ctrl, mem_owner
    );
endinterface

// File: rtl/mio_arbiter.sv
// Two-port arbiter for the shared data-memory/MIO port: round-robin or fixed priority,
// registered outputs, one-cycle ack per transaction and a watchdog that aborts stuck accesses.
module mio_arbiter #(
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input logic          clk,
    input logic          reset,
    mio_arbiter_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic             FixedPrio = (PRIORITY_MODE == 1);
    localparam logic             WdEn      = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_w_q, mem_w_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [2:0]         dm_ctrl_q, dm_ctrl_d;
    logic               owner_q, owner_d;
    logic               ack0_q, ack0_d, err0_q, err0_d;
    logic               ack1_q, ack1_d, err1_q, err1_d;
    logic [31:0]        rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic               elig0, elig1, grant_sel;
    logic               done, done_err;
    logic [31:0]        done_rdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_w_d      = mem_w_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        dm_ctrl_d    = dm_ctrl_q;
        owner_d      = owner_q;
        ack0_d       = 1'b0;
        err0_d       = 1'b0;
        ack1_d       = 1'b0;
        err1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        done         = 1'b0;
        done_err     = 1'b0;
        done_rdata   = '0;

        // A port still holding req during its own ack cycle must not be re-granted.
        elig0 = bus.req0 & ~ack0_q;
        elig1 = bus.req1 & ~ack1_q;
        if (elig0 && elig1) begin
            grant_sel = FixedPrio ? 1'b0 : ~last_grant_q;
        end else begin
            grant_sel = elig1;
        end

        unique case (state_q)
            StIdle: begin
                if (elig0 || elig1) begin
                    state_d      = StBusy;
                    mem_req_d    = 1'b1;
                    owner_d      = grant_sel;
                    last_grant_d = grant_sel;
                    cnt_d        = '0;
                    mem_w_d      = grant_sel ? bus.we1    : bus.we0;
                    mem_addr_d   = grant_sel ? bus.addr1  : bus.addr0;
                    mem_wdata_d  = grant_sel ? bus.wdata1 : bus.wdata0;
                    dm_ctrl_d    = grant_sel ? bus.ctrl1  : bus.ctrl0;
                end
            end
            StBusy: begin
                // mem_ready wins over a watchdog expiry in the same cycle.
                if (bus.mem_ready) begin
                    done       = 1'b1;
                    done_rdata = mem_w_q ? 32'h0 : bus.mem_rdata;
                end else if (WdEn && (cnt_q == CntLast)) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (done) begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
            if (owner_q) begin
                ack1_d   = 1'b1;
                err1_d   = done_err;
                rdata1_d = done_rdata;
            end else begin
                ack0_d   = 1'b1;
                err0_d   = done_err;
                rdata0_d = done_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_w_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            dm_ctrl_q    <= '0;
            owner_q      <= 1'b0;
            ack0_q       <= 1'b0;
            err0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_w_q      <= mem_w_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            dm_ctrl_q    <= dm_ctrl_d;
            owner_q      <= owner_d;
            ack0_q       <= ack0_d;
            err0_q       <= err0_d;
            ack1_q       <= ack1_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_w     = mem_w_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.dm_ctrl   = dm_ctrl_q;
    assign bus.mem_owner = owner_q;
    assign bus.ack0      = ack0_q;
    assign bus.err0      = err0_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.ack1      = ack1_q;
    assign bus.err1      = err1_q;
    assign bus.rdata1    = rdata1_q;

endmodule
